// File: rtl/conv_row_feeder_if.sv
// conv_row_feeder_if: raster pixel input and column-triple output handshakes
interface conv_row_feeder_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] R1;
  logic [7:0] R2;
  logic [7:0] R3;
  logic [7:0] col_idx;
  logic [7:0] row_idx;
  logic       row_valid;
  logic       row_ready;
  logic       frame_done;
  modport master (
    output pix_in, pix_valid, row_ready,
    input  pix_ready, R1, R2, R3, col_idx, row_idx, row_valid, frame_done
  );
  modport slave (
    input  pix_in, pix_valid, row_ready,
    output pix_ready, R1, R2, R3, col_idx, row_idx, row_valid, frame_done
  );
endinterface

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: turns a raster pixel stream into vertical 3-pixel column triples
module conv_row_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic              clk,
  input logic              reset,
  conv_row_feeder_if.slave io_bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic {FILL, STREAM} state_t;
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_lb1 [IMG_W];
  logic [7:0]    r_lb2 [IMG_W];
  logic [7:0]    r_r1, r_r2, r_r3, r_col_idx, r_row_idx;
  logic          r_row_valid, r_frame_done;
  logic          w_ready, w_accept, w_load, w_col_end, w_row_end;
  always_comb begin
    w_ready    = !reset && (r_state == FILL || !r_row_valid || io_bus.row_ready);
    w_accept   = io_bus.pix_valid && w_ready;
    w_load     = w_accept && r_state == STREAM;
    w_col_end  = r_col == CW'(IMG_W - 1);
    w_row_end  = r_row == RW'(IMG_H - 1);
    w_state_nx = r_state;
    if (w_accept && w_col_end)
      w_state_nx = (r_state == FILL && r_row == RW'(1)) ? STREAM :
                   (r_state == STREAM && w_row_end)     ? FILL   : r_state;
  end
  always_ff @(posedge clk)
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nx;
  always_ff @(posedge clk)
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      r_row <= !w_col_end ? r_row : w_row_end ? '0 : r_row + 1'b1;
    end
  // line buffers are deliberately unreset: FILL rewrites them before any read
  always_ff @(posedge clk)
    if (w_accept) begin
      r_lb1[r_col] <= r_lb2[r_col];
      r_lb2[r_col] <= io_bus.pix_in;
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_r1         <= '0;
      r_r2         <= '0;
      r_r3         <= '0;
      r_col_idx    <= '0;
      r_row_idx    <= '0;
      r_row_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (w_load) begin
      r_r1         <= r_lb1[r_col];
      r_r2         <= r_lb2[r_col];
      r_r3         <= io_bus.pix_in;
      r_col_idx    <= 8'(r_col);
      r_row_idx    <= 8'(r_row);
      r_row_valid  <= 1'b1;
      r_frame_done <= w_col_end && w_row_end;
    end else begin
      if (io_bus.row_ready) r_row_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end
  assign io_bus.pix_ready  = w_ready;
  assign io_bus.R1         = r_r1;
  assign io_bus.R2         = r_r2;
  assign io_bus.R3         = r_r3;
  assign io_bus.col_idx    = r_col_idx;
  assign io_bus.row_idx    = r_row_idx;
  assign io_bus.row_valid  = r_row_valid;
  assign io_bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_row_feeder.sv
// tb_conv_row_feeder: scoreboard bench for conv_row_feeder on a 4x4 image
module tb_conv_row_feeder;
  typedef struct {
    logic [39:0] v;
    bit          last;
    int          cyc;
  } exp_t;
  logic clk = 0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_trip = 0;
  int   n_done = 0;
  bit   prev_valid = 0;
  bit   prev_hs = 0;
  exp_t q[$];
  exp_t e;
  conv_row_feeder_if bus();
  conv_row_feeder #(.IMG_W(4), .IMG_H(4)) dut (.clk(clk), .reset(reset), .io_bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.row_valid) begin
      if (!prev_valid || prev_hs) begin
        check("triple_pending", 40'(q.size() != 0), 40'd1);
        if (q.size() != 0) begin
          check("latency", 40'(cyc), 40'(q[0].cyc + 1));
          check("frame_done", 40'(bus.frame_done), 40'(q[0].last));
        end
      end else
        check("frame_done_hold", 40'(bus.frame_done), 40'd0);
    end else
      check("frame_done_idle", 40'(bus.frame_done), 40'd0);
    if (bus.frame_done) n_done++;
    if (bus.row_valid && bus.row_ready) begin
      n_trip++;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("triple", {bus.R1, bus.R2, bus.R3, bus.col_idx, bus.row_idx}, e.v);
      end
    end
    prev_valid = bus.row_valid;
    prev_hs    = bus.row_valid && bus.row_ready;
  end
  task automatic send_frame(input logic [7:0] base, input bit gaps, input int n_pix);
    exp_t x_e;
    int   n;
    for (int i = 0; i < n_pix; i++) begin
      logic [7:0] x = 8'(i % 4);
      logic [7:0] y = 8'(i / 4);
      if (gaps)
        while ($urandom_range(0, 1) == 1) begin
          bus.pix_valid = 0;
          @(posedge clk);
          #1;
        end
      bus.pix_in    = base + 8'(16) * y + x;
      bus.pix_valid = 1;
      n = 0;
      @(negedge clk);
      while (!bus.pix_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!bus.pix_ready) begin
        check("pix_accept_timeout", 40'(bus.pix_ready), 40'd1);
        bus.pix_valid = 0;
        return;
      end
      if (y >= 2) begin
        x_e.v    = {base + 8'(16) * (y - 8'd2) + x, base + 8'(16) * (y - 8'd1) + x,
                    base + 8'(16) * y + x, x, y};
        x_e.last = (x == 3 && y == 3);
        x_e.cyc  = cyc;
        q.push_back(x_e);
      end
      @(posedge clk);
      #1;
    end
    bus.pix_valid = 0;
  endtask
  task automatic drain(input int exp_trip, input int exp_done);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 40'(q.size()), 40'd0);
    check("triple_count", 40'(n_trip), 40'(exp_trip));
    check("done_count", 40'(n_done), 40'(exp_done));
    n_trip = 0;
    n_done = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int cycles);
    reset = 1;
    bus.pix_valid = 0;
    repeat (cycles) begin
      @(negedge clk);
      check("ready_in_reset", 40'(bus.pix_ready), 40'd0);
    end
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    @(negedge clk);
    n_trip = 0;
    n_done = 0;
    check("rst_outputs", {bus.R1, bus.R2, bus.R3, bus.col_idx, bus.row_idx}, 40'd0);
    check("rst_flags", 40'({bus.row_valid, bus.frame_done}), 40'd0);
    check("rst_ready", 40'(bus.pix_ready), 40'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic stall_at_1_2();
    int  n = 0;
    bit  found = 0;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      found = bus.row_valid && bus.col_idx == 1 && bus.row_idx == 2;
      n++;
    end
    check("stall_found", 40'(found), 40'd1);
    if (!found) return;
    bus.row_ready = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_triple", {bus.R1, bus.R2, bus.R3, bus.col_idx, bus.row_idx},
            {8'h01, 8'h11, 8'h21, 8'd1, 8'd2});
      check("stall_valid", 40'(bus.row_valid), 40'd1);
      check("stall_ready", 40'(bus.pix_ready), 40'd0);
    end
    @(posedge clk);
    #1;
    bus.row_ready = 1;
  endtask
  initial begin
    bus.pix_in    = 0;
    bus.pix_valid = 0;
    bus.row_ready = 1;
    do_reset(3);
    send_frame(8'h00, 0, 16);
    drain(8, 1);
    fork
      send_frame(8'h00, 0, 16);
      stall_at_1_2();
    join
    drain(8, 1);
    send_frame(8'h00, 1, 16);
    drain(8, 1);
    send_frame(8'h00, 0, 16);
    send_frame(8'h80, 0, 16);
    drain(16, 2);
    send_frame(8'h00, 0, 14);
    do_reset(1);
    send_frame(8'h00, 0, 16);
    drain(8, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_row_feeder.md
CONV_ROW_FEEDER -- requirements
Module: conv_row_feeder

Interface
REQ-001 Parameter IMG_W, default 8: pixels per image row; legal range 3..256.
REQ-002 Parameter IMG_H, default 8: rows per frame; legal range 3..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 pix_in  input  8  raster-order pixel from the source stream.
REQ-006 pix_valid  input  1  pix_in valid; a pixel is accepted when pix_valid and pix_ready are both 1.
REQ-007 pix_ready  output  1  block can accept a pixel this cycle.
REQ-008 R1  output  8  pixel at (col, row-2); feeds the top kernel row.
REQ-009 R2  output  8  pixel at (col, row-1); feeds the middle kernel row.
REQ-010 R3  output  8  pixel at (col, row); feeds the bottom kernel row.
REQ-011 row_valid  output  1  R1/R2/R3/col_idx/row_idx hold a valid column triple.
REQ-012 row_ready  input  1  consumer accepts the triple when row_valid and row_ready are both 1.
REQ-013 col_idx  output  8  column of the emitted triple.
REQ-014 row_idx  output  8  row of R3 in the emitted triple.
REQ-015 frame_done  output  1  one-cycle pulse marking the final triple of a frame.

Function
REQ-016 Internal counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel to be accepted; col increments on every accept; at IMG_W-1 it wraps to 0 and row increments; at (IMG_W-1, IMG_H-1) both wrap to 0.
REQ-017 Two line buffers, LB1 (row-2) and LB2 (row-1), each hold IMG_W x 8 bits, indexed by col.
REQ-018 On every accept at column x: LB1[x] <= LB2[x], LB2[x] <= pix_in, in the same cycle.
REQ-019 State machine FILL/STREAM: FILL while row is 0 or 1; on accepting pixel (IMG_W-1, 1), move to STREAM; on accepting pixel (IMG_W-1, IMG_H-1), return to FILL.
REQ-020 In FILL, accepts update only the line buffers and counters; the output register is untouched.
REQ-021 In STREAM, an accept at (x, y) loads R1 <= LB1[x], R2 <= LB2[x], R3 <= pix_in, col_idx <= x, row_idx <= y, row_valid <= 1; the values are read before the REQ-018 update.
REQ-022 Latency: the triple for a pixel accepted in cycle t is presented from cycle t+1.
REQ-023 pix_ready = 1 in FILL; in STREAM, pix_ready = !row_valid || row_ready. It is combinational and is 0 while reset is high.
REQ-024 While row_valid=1 and row_ready=0, all of R1/R2/R3/col_idx/row_idx stay stable.
REQ-025 Output handshake with no new load: row_valid clears next cycle. Output handshake with a simultaneous new load: the new triple loads and row_valid stays 1.
REQ-026 frame_done = 1 for exactly one cycle, coincident with the first cycle row_valid presents the (IMG_W-1, IMG_H-1) triple; it does not repeat while that triple stalls.
REQ-027 Each frame emits exactly (IMG_H-2) x IMG_W triples.
REQ-028 Back-to-back frames need no idle cycle. The first two rows of the next frame are accepted in FILL while the last triple of the previous frame may still be pending.
REQ-029 pix_valid=0 holds all state. Gaps in pix_valid never duplicate or drop a triple.

Reset
REQ-030 With reset=1 at a clock edge: state=FILL, col=0, row=0, row_valid=0, R1=R2=R3=0, col_idx=row_idx=0, frame_done=0.
REQ-031 Line-buffer contents are not reset; they are never emitted before being rewritten by FILL.
REQ-032 Reset asserted mid-frame discards the partial frame and any pending triple. The next accepted pixel is treated as (0,0).

Verification (IMG_W=4, IMG_H=4, pixel value = 16*row + col, row_ready=1 unless stated)
REQ-033 Stream one full frame with continuous pix_valid. Required response:
- no row_valid during rows 0-1;
- first triple R1=0x00, R2=0x10, R3=0x20 at col_idx=0, row_idx=2, one cycle after pixel 0x20 is accepted;
- 8 triples in total;
- last triple R1=0x13, R2=0x23, R3=0x33 with frame_done=1.
REQ-034 Hold row_ready=0 for 5 cycles after triple (1,2) appears. Required response: R1=0x01, R2=0x11, R3=0x21 stable, pix_ready=0, no pixel accepted; when row_ready returns to 1, the stream resumes with triple (2,2) and no loss.
REQ-035 Randomly gap pix_valid (about 50% duty). Required response: the triple sequence is identical to REQ-033 and frame_done pulses once.
REQ-036 Send two back-to-back frames, the second offset by +0x80. Required response: the second frame's first triple is 0x80/0x90/0xA0, with no stale first-frame data; 16 triples and 2 frame_done pulses in total.
REQ-037 Assert reset for 1 cycle after pixel 0x31 is accepted, then send a fresh frame. Required response: row_valid=0 and all outputs 0 after reset; the fresh frame reproduces exactly the REQ-033 sequence.
